// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and types for the fetch-stage program counter
package pc_pkg;

  localparam int          XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int          PC_INCR              = 4;

  typedef logic [XLEN_DEFAULT-1:0] pc_t;

  // Instructions are 4-byte words; any set low bit marks a misaligned target.
  function automatic logic addr_misaligned(input logic [1:0] low_bits);
    return |low_bits;
  endfunction

endpackage

// File: rtl/pc_reg_if.sv
// rtl/pc_reg_if.sv - next-PC input and fetch-side status bundle (stall present when PC_STALL_EN is defined)
interface pc_reg_if #(
  parameter int XLEN = pc_pkg::XLEN_DEFAULT
);

  logic [XLEN-1:0] pc_next;
`ifdef PC_STALL_EN
  logic            stall;
`endif
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_prev;
  logic            misalign;
  logic            pc_valid;

`ifdef PC_STALL_EN
  modport master (output pc_next, output stall,
                  input pc, input pc_plus4, input pc_prev, input misalign, input pc_valid);
  modport slave  (input pc_next, input stall,
                  output pc, output pc_plus4, output pc_prev, output misalign, output pc_valid);
`else
  modport master (output pc_next,
                  input pc, input pc_plus4, input pc_prev, input misalign, input pc_valid);
  modport slave  (input pc_next,
                  output pc, output pc_plus4, output pc_prev, output misalign, output pc_valid);
`endif

endinterface

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - RV32I fetch program-counter register; optional fetch stall under PC_STALL_EN
module pc_reg
  import pc_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT[XLEN-1:0],
  parameter bit              FORCE_ALIGN  = 1'b1
) (
  input  logic    clk,
  input  logic    reset,
  pc_reg_if.slave bus
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_prev_q;
  logic            misalign_q;
  logic            pc_valid_q;
  logic [XLEN-1:0] load_addr;
  logic            hold;

  always_comb begin
    load_addr = bus.pc_next;
    if (FORCE_ALIGN) begin
      load_addr[1:0] = 2'b00;
    end
  end

`ifdef PC_STALL_EN
  assign hold = bus.stall;
`else
  assign hold = 1'b0;
`endif

  // Misalign looks at the raw target so software sees the fault even when alignment is forced.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      pc_prev_q  <= RESET_VECTOR;
      misalign_q <= 1'b0;
      pc_valid_q <= 1'b0;
    end else begin
      pc_valid_q <= 1'b1;
      if (!hold) begin
        pc_q       <= load_addr;
        pc_prev_q  <= pc_q;
        misalign_q <= addr_misaligned(bus.pc_next[1:0]);
      end
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_q + XLEN'(PC_INCR);
  assign bus.pc_prev  = pc_prev_q;
  assign bus.misalign = misalign_q;
  assign bus.pc_valid = pc_valid_q;

endmodule

// File: tb/tb_pc_reg.sv
// tb/tb_pc_reg.sv - scoreboard bench for pc_reg; exercises stall when PC_STALL_EN is defined
module tb_pc_reg;

  localparam logic [31:0] RV = 32'h0000_0000;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] plus4;
    logic [31:0] prev;
    logic        mis;
    logic        valid;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  logic [31:0] m_pc, m_prev;
  logic        m_mis, m_valid;

  pc_reg_if #(.XLEN(32)) bus ();

  pc_reg #(.XLEN(32), .RESET_VECTOR(RV), .FORCE_ALIGN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic [31:0] nxt, input logic st);
    exp_t e;
    reset       = rst;
    bus.pc_next = nxt;
`ifdef PC_STALL_EN
    bus.stall   = st;
`endif
    if (rst) begin
      m_pc = RV; m_prev = RV; m_mis = 1'b0; m_valid = 1'b0;
    end else begin
      m_valid = 1'b1;
      if (!st) begin
        m_prev = m_pc;
        m_pc   = {nxt[31:2], 2'b00};
        m_mis  = (nxt[1:0] != 2'b00);
      end
    end
    e.tag = tag; e.pc = m_pc; e.plus4 = m_pc + 32'd4; e.prev = m_prev;
    e.mis = m_mis; e.valid = m_valid;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".pc"},       bus.pc,               e.pc);
    check({e.tag, ".plus4"},    bus.pc_plus4,         e.plus4);
    check({e.tag, ".prev"},     bus.pc_prev,          e.prev);
    check({e.tag, ".misalign"}, {31'd0, bus.misalign}, {31'd0, e.mis});
    check({e.tag, ".valid"},    {31'd0, bus.pc_valid}, {31'd0, e.valid});
  endtask

  initial begin
    bus.pc_next = '0;
`ifdef PC_STALL_EN
    bus.stall = 1'b0;
`endif
    @(negedge clk);
    step("reset", 1'b1, 32'h0, 1'b0);
    check("reset_pc_const", bus.pc, RV);

    for (int i = 1; i <= 5; i++) begin
      step($sformatf("seq%0d", i), 1'b0, 32'(i * 4), 1'b0);
    end
    check("seq_pc_const", bus.pc, 32'd20);
    check("seq_prev_const", bus.pc_prev, 32'd16);

    step("mis106", 1'b0, 32'h0000_0106, 1'b0);
    check("mis106_pc_const", bus.pc, 32'h0000_0104);
    check("mis106_flag_const", {31'd0, bus.misalign}, 32'd1);
    step("align108", 1'b0, 32'h0000_0108, 1'b0);

    step("wrap", 1'b0, 32'hFFFF_FFFC, 1'b0);
    check("wrap_plus4_const", bus.pc_plus4, 32'h0000_0000);

    step("pre16", 1'b0, 32'd16, 1'b0);
    step("midreset", 1'b1, 32'd20, 1'b0);
    check("midreset_valid_const", {31'd0, bus.pc_valid}, 32'd0);
    step("post24", 1'b0, 32'd24, 1'b0);
    check("post24_pc_const", bus.pc, 32'd24);
    step("selfloop", 1'b0, 32'd24, 1'b0);
    check("selfloop_prev_const", bus.pc_prev, 32'd24);

    for (int i = 0; i < 8; i++) begin
      step($sformatf("rand%0d", i), 1'b0, $urandom, 1'b0);
    end

`ifdef PC_STALL_EN
    step("st_pre8", 1'b0, 32'd8, 1'b0);
    step("stall_a", 1'b0, 32'd12, 1'b1);
    step("stall_b", 1'b0, 32'd13, 1'b1);
    check("stall_pc_const", bus.pc, 32'd8);
    step("unstall", 1'b0, 32'd12, 1'b0);
    check("unstall_pc_const", bus.pc, 32'd12);
    step("rst_stall", 1'b1, 32'd40, 1'b1);
    check("rst_stall_pc_const", bus.pc, RV);
    step("after_rst_stall", 1'b0, 32'd44, 1'b1);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pc_reg.md
Name: pc_reg

Overview:
- Program-counter register for the RV32I pipelined core, at the head of the fetch stage.
- Loads the next fetch address (pc_next, chosen upstream by the next-PC mux) on every rising clock edge.
- Presents the current address to instruction memory, plus derived fetch-side status: pc+4, previous PC, alignment error and a post-reset valid flag.

Parameters:
- XLEN, 32, datapath width in bits.
- RESET_VECTOR, 32'h0000_0000, value loaded into pc on reset; must be 4-byte aligned.
- FORCE_ALIGN, 1, when 1 bits [1:0] of the loaded address are forced to 0.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- pc_next  input  XLEN  next fetch address.
- pc  output  XLEN  current fetch address (registered).
- pc_plus4  output  XLEN  pc + 4 (combinational from pc), modulo 2^XLEN.
- pc_prev  output  XLEN  value pc held before the last load (registered).
- misalign  output  1  registered; 1 when the most recently loaded pc_next had bits [1:0] != 0.
- pc_valid  output  1  registered; 0 during reset and for the first cycle after it, then 1.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset at posedge while reset=1:
  - pc = RESET_VECTOR, pc_prev = RESET_VECTOR.
  - misalign = 0, pc_valid = 0.
  - pc_next is ignored.
- Normal operation, posedge with reset=0:
  - pc <= pc_next. If FORCE_ALIGN=1, bits [1:0] are cleared; otherwise pc_next is loaded unmodified.
  - pc_prev <= old pc.
  - misalign <= (pc_next[1:0] != 0), evaluated on the raw pc_next regardless of FORCE_ALIGN.
  - pc_valid <= 1.
- Latency: one cycle from pc_next to pc. No combinational path from pc_next to any output.
- pc_plus4 wraps: pc = 32'hFFFF_FFFC gives pc_plus4 = 32'h0000_0000. No overflow flag.
- Reset asserted mid-run: the next posedge overrides any pc_next and returns all outputs to reset values. Deassertion takes effect at the following edge with no extra delay.
- pc_next equal to pc (self-loop) is legal: pc holds and pc_prev becomes equal to pc.
- There is no handshake; the register loads unconditionally every cycle unless the optional stall is compiled in.
- Outputs before the first reset edge are X; this is not specified.

Optional Feature:
- Macro: PC_STALL_EN.
- Defined: adds input port stall (1 bit), placed after pc_next.
  - stall=1 with reset=0 holds pc, pc_prev and misalign unchanged.
  - pc_valid still sets to 1.
  - reset has priority over stall.
- Undefined: no stall port; the register loads every cycle.

Decomposition:
- Shared package pc_pkg holds:
  - XLEN default;
  - RESET_VECTOR default;
  - constant PC_INCR = 4;
  - typedef pc_t (logic [XLEN-1:0]).
- The core fetch and next-PC logic import pc_pkg.
- No sub-module is needed. The incrementer is a single adder kept inline.

Test Plan:
- Reset load: reset=1 for one edge with pc_next=0 → pc=0, pc_prev=0, pc_valid=0, misalign=0.
- Sequential fetch: release reset, drive pc_next = 4, 8, 12, 16, 20 on successive cycles → after each edge pc follows one cycle late (4, 8, 12, 16, 20). pc_prev lags by one (0, 4, 8, 12, 16). pc_plus4 = pc+4. pc_valid=1 from the first post-reset edge.
- Misaligned target: pc_next=32'h0000_0106 with FORCE_ALIGN=1 → pc=32'h0000_0104, misalign=1. A following pc_next=32'h108 clears misalign to 0.
- Wrap-around: pc_next=32'hFFFF_FFFC → pc=32'hFFFF_FFFC, pc_plus4=0.
- Reset mid-run: pc=16, then assert reset for one edge with pc_next=20 → pc=RESET_VECTOR. Deasserting with pc_next=24 gives pc=24 at the next edge.
- PC_STALL_EN: pc=8, stall=1 for two edges with pc_next=12 → pc stays 8. Stall=0 → pc=12 at the next edge. Reset=1 together with stall=1 → pc=RESET_VECTOR.
